// File: rtl/pwr_est_pkg.sv
// Shared definitions for the switching-activity power estimation blocks.
package pwr_est_pkg;

  // Default toggle counter width, also used by the downstream power accumulator
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/toggle_counter.sv
// One monitored net: previous-sample flop, XOR toggle detect and a
// saturating toggle counter with clear and enable.
module toggle_counter
  import pwr_est_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample,
  input  logic             en,
  input  logic             sig,
  output logic [CNT_W-1:0] cnt
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog;

  // Track the previous sample and bump the count on a toggle, sticking at all-ones
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    tog    = sig ^ prev_q;
    if (sample) begin
      prev_d = sig;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (en && tog && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Register the sample and count; reset clears both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/toggle_window_ctrl.sv
// Measurement sequencer: counts toggles on NUM_CH nets over a window of
// win_len cycles, then streams one count per channel over valid/ready.
module toggle_window_ctrl
  import pwr_est_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = DEFAULT_CNT_W,
  parameter  int WIN_W  = 16,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              abort,
  input  logic [NUM_CH-1:0] sig_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_ch,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_last,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_arr [NUM_CH];
  logic             cnt_clr, cnt_sample, cnt_en;

  // Counters are cleared on arming and on any abort of a live measurement
  assign cnt_clr    = (state_q == ST_ARM) || (abort && (state_q != ST_IDLE));
  assign cnt_sample = (state_q == ST_ARM) || (state_q == ST_COUNT);
  assign cnt_en     = (state_q == ST_COUNT);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    toggle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .sample (cnt_sample),
      .en     (cnt_en),
      .sig    (sig_in[g]),
      .cnt    (cnt_arr[g])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides window end and the final transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (win_len != '0)) state_d = ST_ARM;
      ST_ARM:   state_d = ST_COUNT;
      ST_COUNT: if (win_cnt_q == WIN_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (out_ready && (idx_q == LAST_IDX)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  // Window length latch, window down-counter and drain index
  always_comb begin
    win_len_d = win_len_q;
    win_cnt_d = win_cnt_q;
    idx_d     = idx_q;
    case (state_q)
      ST_IDLE:  if (start) win_len_d = win_len;
      ST_ARM: begin
        win_cnt_d = win_len_q;
        idx_d     = '0;
      end
      ST_COUNT: win_cnt_d = win_cnt_q - WIN_W'(1);
      ST_DRAIN: begin
        if (out_ready) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      ST_DONE:  idx_d = '0;
      default:  ;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      win_cnt_d = '0;
      idx_d     = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_len_q <= '0;
      win_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      win_len_q <= win_len_d;
      win_cnt_q <= win_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Outputs decoded from state; the result fields read zero outside DRAIN
  always_comb begin
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
    out_ch    = '0;
    out_cnt   = '0;
    out_last  = 1'b0;
    if (state_q == ST_DRAIN) begin
      out_ch   = idx_q;
      out_cnt  = cnt_arr[idx_q];
      out_last = (idx_q == LAST_IDX);
    end
  end

endmodule
